// File: rtl/prl_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : prl_tx_arbiter
//  Purpose  : USB-PD protocol-layer transmit arbiter. Grants one of Hard Reset,
//             Cable Reset or SOP* message requests (HR > CR > MSG), runs one
//             PHY transmission with a timeout, and reports the outcome through
//             ALERT pulses and a sticky stop_attempting flag.
//  Ports    : CLK, reset_n (async, active-low)
//             hr_req / cr_req / msg_req   level requests, held until req_ack
//             msg_type[2:0]               TRANSMIT code, sampled at grant
//             req_ack[2:0]                one-hot grant pulse {HR,CR,MSG}
//             phy_tx_start / phy_tx_type  PHY start pulse and type code
//             phy_tx_done / phy_tx_fail   PHY completion pulses
//             busy, alert_success, alert_failed, stop_attempting
//  Params   : TIMEOUT (2..1023), RETRY_MAX
//  Options  : define TX_RETRY_EN to retry failed SOP* messages up to RETRY_MAX
//  Revision : 1.0  initial release
// ============================================================================
module prl_tx_arbiter #(
    parameter int TIMEOUT   = 900,
    parameter int RETRY_MAX = 3
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       hr_req,
    input  logic       cr_req,
    input  logic       msg_req,
    input  logic [2:0] msg_type,
    output logic [2:0] req_ack,
    output logic       phy_tx_start,
    output logic [2:0] phy_tx_type,
    input  logic       phy_tx_done,
    input  logic       phy_tx_fail,
    output logic       busy,
    output logic       alert_success,
    output logic       alert_failed,
    output logic       stop_attempting
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_SUCCESS = 3'd3,
        ST_FAIL    = 3'd4
    } state_t;

    localparam logic [2:0] c_gnt_hr     = 3'b100;
    localparam logic [2:0] c_gnt_cr     = 3'b010;
    localparam logic [2:0] c_gnt_msg    = 3'b001;
    localparam logic [2:0] c_type_hr    = 3'b101;
    localparam logic [2:0] c_type_cr    = 3'b110;
    localparam logic [9:0] c_timer_last = 10'(TIMEOUT - 1);

    if (TIMEOUT < 2 || TIMEOUT > 1023 || RETRY_MAX < 0) begin : g_param_check
        $error("prl_tx_arbiter: TIMEOUT or RETRY_MAX out of range");
    end

    state_t     state_q, state_d;
    logic [9:0] timer_q, timer_d;
    logic [2:0] type_q,  type_d;
    logic [2:0] gnt_q,   gnt_d;     // which request owns the current transfer
    logic [2:0] ack_q,   ack_d;
    logic       start_q, start_d;
    logic       stop_q,  stop_d;

`ifdef TX_RETRY_EN
    localparam int              c_retry_w   = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam logic [c_retry_w-1:0] c_retry_max = c_retry_w'(RETRY_MAX);
    logic [c_retry_w-1:0] retry_q, retry_d;
`endif

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        type_d  = type_q;
        gnt_d   = gnt_q;
        ack_d   = 3'b000;
        start_d = 1'b0;
        stop_d  = stop_q;
`ifdef TX_RETRY_EN
        retry_d = retry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (hr_req) begin
                    gnt_d   = c_gnt_hr;
                    type_d  = c_type_hr;
                    state_d = ST_START;
                end else if (cr_req) begin
                    gnt_d   = c_gnt_cr;
                    type_d  = c_type_cr;
                    state_d = ST_START;
                end else if (msg_req) begin
                    gnt_d   = c_gnt_msg;
                    type_d  = msg_type;
                    state_d = ST_START;
                end
                if (hr_req || cr_req || msg_req) begin
                    ack_d = gnt_d;
`ifdef TX_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            ST_START: begin
                // start_q lands in the first WAIT cycle, one cycle after req_ack
                start_d = 1'b1;
                timer_d = 10'd0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                timer_d = timer_q + 10'd1;
                // A finished transfer takes precedence over an HR preemption
                if (phy_tx_done) begin
                    state_d = ST_SUCCESS;
                end else if (phy_tx_fail || timer_q == c_timer_last) begin
`ifdef TX_RETRY_EN
                    if (gnt_q == c_gnt_msg && retry_q < c_retry_max) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_FAIL;
                    end
`else
                    state_d = ST_FAIL;
`endif
                end else if (hr_req && gnt_q != c_gnt_hr) begin
                    gnt_d   = c_gnt_hr;
                    type_d  = c_type_hr;
                    ack_d   = c_gnt_hr;
                    state_d = ST_START;
`ifdef TX_RETRY_EN
                    retry_d = '0;
`endif
                end
            end
            ST_SUCCESS: begin
                state_d = ST_IDLE;
            end
            ST_FAIL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // stop_attempting changes in the same cycle the outcome is reported
        if (state_d == ST_FAIL && gnt_d != c_gnt_msg) begin
            stop_d = 1'b1;
        end else if (state_d == ST_SUCCESS && gnt_d == c_gnt_hr) begin
            stop_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            timer_q <= 10'd0;
            type_q  <= 3'b000;
            gnt_q   <= 3'b000;
            ack_q   <= 3'b000;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
`ifdef TX_RETRY_EN
            retry_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            type_q  <= type_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            stop_q  <= stop_d;
`ifdef TX_RETRY_EN
            retry_q <= retry_d;
`endif
        end
    end

    assign req_ack         = ack_q;
    assign phy_tx_start    = start_q;
    assign phy_tx_type     = type_q;
    assign busy            = (state_q != ST_IDLE);
    assign alert_success   = (state_q == ST_SUCCESS);
    assign alert_failed    = (state_q == ST_FAIL);
    assign stop_attempting = stop_q;

endmodule
`default_nettype wire

// File: tb/tb_prl_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_prl_tx_arbiter
//  Purpose  : Self-checking bench for prl_tx_arbiter. A background monitor
//             logs grants and PHY/alert events and drops each request when it
//             is acknowledged; a PHY responder answers start pulses according
//             to the selected mode. Scenario tasks compare the logged events
//             with transaction-level expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prl_tx_arbiter;

    localparam int TIMEOUT   = 900;
    localparam int RETRY_MAX = 3;
`ifdef TX_RETRY_EN
    localparam int MSG_TRIES = RETRY_MAX + 1;
`else
    localparam int MSG_TRIES = 1;
`endif
    localparam int M_NONE = 0, M_DONE = 1, M_FAIL = 2, M_BOTH = 3;
    localparam int BOUND  = 12000;

    logic       CLK = 1'b0;
    logic       reset_n;
    logic       hr_req, cr_req, msg_req;
    logic [2:0] msg_type;
    logic [2:0] req_ack;
    logic       phy_tx_start;
    logic [2:0] phy_tx_type;
    logic       phy_tx_done, phy_tx_fail;
    logic       busy, alert_success, alert_failed, stop_attempting;

    always #5 CLK = ~CLK;

    prl_tx_arbiter #(.TIMEOUT(TIMEOUT), .RETRY_MAX(RETRY_MAX)) dut (
        .CLK             (CLK),
        .reset_n         (reset_n),
        .hr_req          (hr_req),
        .cr_req          (cr_req),
        .msg_req         (msg_req),
        .msg_type        (msg_type),
        .req_ack         (req_ack),
        .phy_tx_start    (phy_tx_start),
        .phy_tx_type     (phy_tx_type),
        .phy_tx_done     (phy_tx_done),
        .phy_tx_fail     (phy_tx_fail),
        .busy            (busy),
        .alert_success   (alert_success),
        .alert_failed    (alert_failed),
        .stop_attempting (stop_attempting)
    );

    int n_cmp = 0, n_err = 0;
    int cyc = 0, cnt_start = 0, cnt_succ = 0, cnt_fail = 0;
    int last_start_cyc = 0, last_fail_cyc = 0, last_ack_cyc = 0;
    logic [5:0] grants[$];
    int mode  = M_NONE;
    int delay = 1;

    // Monitor / requester: logs events and releases acknowledged requests
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            n_cmp++;
            if (!(req_ack == 3'b000 || $onehot(req_ack))) begin
                n_err++;
                $display("FAIL ack_onehot: req_ack=%b, required zero or one-hot", req_ack);
            end
            n_cmp++;
            if (alert_success && alert_failed) begin
                n_err++;
                $display("FAIL alert_exclusive: success=1 failed=1, required at most one");
            end
            if (req_ack != 3'b000) begin
                grants.push_back({req_ack, phy_tx_type});
                last_ack_cyc = cyc;
                if (req_ack[2]) hr_req = 1'b0;
                if (req_ack[1]) cr_req = 1'b0;
                if (req_ack[0]) msg_req = 1'b0;
            end
            if (phy_tx_start) begin
                cnt_start++;
                last_start_cyc = cyc;
            end
            if (alert_success) cnt_succ++;
            if (alert_failed) begin
                cnt_fail++;
                last_fail_cyc = cyc;
            end
        end
    end

    // PHY responder: answers each start pulse after 'delay' cycles
    initial begin
        phy_tx_done = 1'b0;
        phy_tx_fail = 1'b0;
        forever begin
            @(negedge CLK);
            if (phy_tx_start && mode != M_NONE) begin
                repeat (delay) @(negedge CLK);
                phy_tx_done = (mode == M_DONE || mode == M_BOTH);
                phy_tx_fail = (mode == M_FAIL || mode == M_BOTH);
                @(negedge CLK);
                phy_tx_done = 1'b0;
                phy_tx_fail = 1'b0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic settle(input string name);
        int c = 0;
        repeat (2) @(negedge CLK);
        while ((busy || hr_req || cr_req || msg_req) && c < BOUND) begin
            @(negedge CLK);
            c++;
        end
        n_cmp++;
        if (c >= BOUND) begin
            n_err++;
            $display("FAIL %s_settle: busy=%b after %0d cycles, required idle", name, busy, c);
        end
    endtask

    task automatic wait_start(input string name);
        int c = 0;
        while (!phy_tx_start && c < 50) begin
            @(negedge CLK);
            c++;
        end
        n_cmp++;
        if (c >= 50) begin
            n_err++;
            $display("FAIL %s_start: no phy_tx_start within %0d cycles, required one", name, c);
        end
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        hr_req   = 1'b0;
        cr_req   = 1'b0;
        msg_req  = 1'b0;
        msg_type = 3'b000;
        mode     = M_NONE;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({req_ack, phy_tx_start, phy_tx_type, busy, alert_success, alert_failed, stop_attempting} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, required all zero",
                     {req_ack, phy_tx_start, phy_tx_type, busy, alert_success, alert_failed, stop_attempting});
        end
        reset_n = 1'b1;
        repeat (2) @(negedge CLK);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_basic_msg();
        int bg = grants.size(), bs = cnt_start, bo = cnt_succ, bf = cnt_fail;
        mode = M_DONE; delay = 5; msg_type = 3'b000; msg_req = 1'b1;
        settle("basic");
        n_cmp++;
        if (grants.size() != bg + 1) begin
            n_err++; $display("FAIL basic_grants: got %0d, required 1", grants.size() - bg);
        end else begin
            n_cmp++;
            if (grants[bg] !== 6'b001_000) begin
                n_err++; $display("FAIL basic_ack_type: got %b, required 001000", grants[bg]);
            end
        end
        n_cmp++;
        if (last_start_cyc - last_ack_cyc != 1) begin
            n_err++; $display("FAIL basic_latency: got %0d, required 1", last_start_cyc - last_ack_cyc);
        end
        n_cmp++;
        if (cnt_start - bs != 1 || cnt_succ - bo != 1 || cnt_fail - bf != 0) begin
            n_err++; $display("FAIL basic_counts: start=%0d succ=%0d fail=%0d, required 1/1/0",
                              cnt_start - bs, cnt_succ - bo, cnt_fail - bf);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL basic_busy: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_priority();
        logic [5:0] exp [3];
        int bg = grants.size(), bo = cnt_succ;
        exp[0] = 6'b100_101; exp[1] = 6'b010_110; exp[2] = 6'b001_011;
        mode = M_DONE; delay = 3; msg_type = 3'b011;
        hr_req = 1'b1; cr_req = 1'b1; msg_req = 1'b1;
        settle("priority");
        n_cmp++;
        if (grants.size() != bg + 3) begin
            n_err++; $display("FAIL priority_grants: got %0d, required 3", grants.size() - bg);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (grants[bg + i] !== exp[i]) begin
                    n_err++; $display("FAIL priority_order[%0d]: got %b, required %b", i, grants[bg + i], exp[i]);
                end
            end
        end
        n_cmp++;
        if (cnt_succ - bo != 3) begin
            n_err++; $display("FAIL priority_success: got %0d, required 3", cnt_succ - bo);
        end
    endtask

    task automatic test_hr_timeout();
        int bf = cnt_fail, bo;
        mode = M_NONE; hr_req = 1'b1;
        settle("hr_timeout");
        n_cmp++;
        if (cnt_fail - bf != 1) begin
            n_err++; $display("FAIL hr_timeout_alert: got %0d, required 1", cnt_fail - bf);
        end
        n_cmp++;
        if (last_fail_cyc - last_start_cyc != TIMEOUT) begin
            n_err++; $display("FAIL hr_timeout_cycles: got %0d, required %0d", last_fail_cyc - last_start_cyc, TIMEOUT);
        end
        n_cmp++;
        if (stop_attempting !== 1'b1) begin
            n_err++; $display("FAIL hr_timeout_stop: got %b, required 1", stop_attempting);
        end
        bo = cnt_succ;
        mode = M_DONE; delay = 2; hr_req = 1'b1;
        settle("hr_recover");
        n_cmp++;
        if (stop_attempting !== 1'b0 || cnt_succ - bo != 1) begin
            n_err++; $display("FAIL hr_recover: stop=%b succ=%0d, required 0/1", stop_attempting, cnt_succ - bo);
        end
    endtask

    task automatic test_preempt();
        int bg = grants.size(), bs = cnt_start, bo = cnt_succ, bf = cnt_fail;
        mode = M_NONE; msg_type = 3'b010; msg_req = 1'b1;
        wait_start("preempt");
        repeat (3) @(negedge CLK);
        hr_req = 1'b1;
        @(negedge CLK);
        mode = M_DONE; delay = 4;
        n_cmp++;
        if (req_ack !== 3'b100 || phy_tx_type !== 3'b101) begin
            n_err++; $display("FAIL preempt_ack: ack=%b type=%b, required 100/101", req_ack, phy_tx_type);
        end
        settle("preempt");
        n_cmp++;
        if (cnt_fail - bf != 0 || cnt_succ - bo != 1 || cnt_start - bs != 2 || grants.size() - bg != 2) begin
            n_err++; $display("FAIL preempt_counts: fail=%0d succ=%0d start=%0d grants=%0d, required 0/1/2/2",
                              cnt_fail - bf, cnt_succ - bo, cnt_start - bs, grants.size() - bg);
        end
    endtask

    task automatic test_retry();
        int bs = cnt_start, bo = cnt_succ, bf = cnt_fail;
        mode = M_FAIL; delay = 2; msg_type = 3'b001; msg_req = 1'b1;
        settle("retry");
        n_cmp++;
        if (cnt_start - bs != MSG_TRIES) begin
            n_err++; $display("FAIL retry_starts: got %0d, required %0d", cnt_start - bs, MSG_TRIES);
        end
        n_cmp++;
        if (cnt_fail - bf != 1 || cnt_succ - bo != 0) begin
            n_err++; $display("FAIL retry_alerts: fail=%0d succ=%0d, required 1/0", cnt_fail - bf, cnt_succ - bo);
        end
        n_cmp++;
        if (stop_attempting !== 1'b0) begin
            n_err++; $display("FAIL retry_stop: got %b, required 0", stop_attempting);
        end
    endtask

    task automatic test_done_fail();
        int bo = cnt_succ, bf = cnt_fail;
        mode = M_BOTH; delay = 3; msg_req = 1'b1;
        settle("done_fail");
        n_cmp++;
        if (cnt_succ - bo != 1 || cnt_fail - bf != 0) begin
            n_err++; $display("FAIL done_fail: succ=%0d fail=%0d, required 1/0", cnt_succ - bo, cnt_fail - bf);
        end
    endtask

    task automatic test_reset_mid_wait();
        int bs = cnt_start, bf;
        mode = M_FAIL; delay = 2; cr_req = 1'b1;
        settle("cr_fail");
        n_cmp++;
        if (stop_attempting !== 1'b1 || cnt_start - bs != 1) begin
            n_err++; $display("FAIL cr_fail: stop=%b starts=%0d, required 1/1", stop_attempting, cnt_start - bs);
        end
        mode = M_NONE; cr_req = 1'b1;
        wait_start("reset_mid");
        repeat (4) @(negedge CLK);
        @(posedge CLK);
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({req_ack, phy_tx_start, phy_tx_type, busy, alert_success, alert_failed, stop_attempting} !== 11'd0) begin
            n_err++;
            $display("FAIL reset_async: got %b, required all zero",
                     {req_ack, phy_tx_start, phy_tx_type, busy, alert_success, alert_failed, stop_attempting});
        end
        bf = cnt_fail;
        repeat (2) @(negedge CLK);
        reset_n = 1'b1;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (cnt_fail != bf || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_abort: alerts=%0d busy=%b, required 0/0", cnt_fail - bf, busy);
        end
    endtask

    task automatic test_random();
        logic exp_stop = 1'b0;
        for (int t = 0; t < 30; t++) begin
            logic [2:0] reqs;
            logic [2:0] mt;
            logic [5:0] exp_g [$];
            int m, bg, bs, bo, bf, e_s, e_o, e_f;
            logic ok;
            reqs = 3'($urandom_range(1, 7));
            mt   = 3'($urandom);
            m    = ($urandom_range(0, 9) == 0) ? M_NONE : int'($urandom_range(1, 3));
            bg = grants.size(); bs = cnt_start; bo = cnt_succ; bf = cnt_fail;
            mode = m; delay = int'($urandom_range(1, 15)); msg_type = mt;
            hr_req = reqs[2]; cr_req = reqs[1]; msg_req = reqs[0];
            settle("random");
            // Reference: serve requests in priority order, one outcome each
            ok  = (m == M_DONE || m == M_BOTH);
            e_s = 0; e_o = 0; e_f = 0;
            for (int i = 2; i >= 0; i--) begin
                if (reqs[i]) begin
                    exp_g.push_back({3'(1 << i), (i == 2) ? 3'b101 : (i == 1) ? 3'b110 : mt});
                    if (ok) begin
                        e_o++; e_s++;
                        if (i == 2) exp_stop = 1'b0;
                    end else begin
                        e_f++;
                        e_s += (i == 0) ? MSG_TRIES : 1;
                        if (i != 0) exp_stop = 1'b1;
                    end
                end
            end
            n_cmp++;
            if (grants.size() - bg != exp_g.size()) begin
                n_err++; $display("FAIL random%0d_grants: got %0d, required %0d", t, grants.size() - bg, exp_g.size());
            end else begin
                foreach (exp_g[k]) begin
                    n_cmp++;
                    if (grants[bg + k] !== exp_g[k]) begin
                        n_err++; $display("FAIL random%0d_grant%0d: got %b, required %b", t, k, grants[bg + k], exp_g[k]);
                    end
                end
            end
            n_cmp++;
            if (cnt_start - bs != e_s || cnt_succ - bo != e_o || cnt_fail - bf != e_f) begin
                n_err++; $display("FAIL random%0d_counts: start=%0d succ=%0d fail=%0d, required %0d/%0d/%0d",
                                  t, cnt_start - bs, cnt_succ - bo, cnt_fail - bf, e_s, e_o, e_f);
            end
            n_cmp++;
            if (stop_attempting !== exp_stop) begin
                n_err++; $display("FAIL random%0d_stop: got %b, required %b", t, stop_attempting, exp_stop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_msg();
        test_priority();
        test_hr_timeout();
        test_preempt();
        test_retry();
        test_done_fail();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prl_tx_arbiter.md
PRL_TX_ARBITER -- requirements
Module: prl_tx_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 900: cycles allowed for one PHY transmission before it fails; legal range 2..1023.
REQ-002 Parameter RETRY_MAX, default 3: message retries after the first attempt; used only with TX_RETRY_EN.
REQ-003 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 hr_req  in  1  Hard Reset request; level, held until acknowledged.
REQ-006 cr_req  in  1  Cable Reset request; level, held until acknowledged.
REQ-007 msg_req  in  1  SOP* message request; level, held until acknowledged.
REQ-008 msg_type  in  3  TRANSMIT[2:0] code for the message; sampled at grant.
REQ-009 req_ack  out  3  one-hot grant pulse: [2]=HR, [1]=CR, [0]=MSG.
REQ-010 phy_tx_start  out  1  one-cycle start pulse to the PHY.
REQ-011 phy_tx_type  out  3  type code, valid and stable from start until the transfer ends.
REQ-012 phy_tx_done  in  1  PHY success pulse.
REQ-013 phy_tx_fail  in  1  PHY failure pulse.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 alert_success  out  1  one-cycle pulse (ALERT.TransmitSuccessful).
REQ-016 alert_failed  out  1  one-cycle pulse (ALERT.TransmitSOP*MessageFailed).
REQ-017 stop_attempting  out  1  sticky flag: a Hard Reset or Cable Reset failed.

Function
REQ-018 States SHALL be IDLE, START, WAIT, SUCCESS, FAIL.
REQ-019 IDLE: if any request is high, grant the highest-priority one (HR > CR > MSG), pulse its req_ack bit, latch the type, go to START.
- Latched type: HR 3'b101, CR 3'b110, MSG = msg_type.
REQ-020 START: assert phy_tx_start for exactly one cycle, clear the 10-bit timer to 0, go to WAIT.
REQ-021 WAIT: increment the timer every cycle.
- phy_tx_done -> SUCCESS.
- Else phy_tx_fail, or timer == TIMEOUT-1 -> FAIL.
- done and fail in the same cycle: done wins.
REQ-022 WAIT with a CR or MSG grant: hr_req high preempts.
- Pulse req_ack[2], latch 3'b101, go to START.
- No alert is raised for the aborted transfer.
REQ-023 WAIT with an HR grant: hr_req is ignored.
REQ-024 SUCCESS: pulse alert_success for one cycle, go to IDLE; if the grant was HR, clear stop_attempting.
REQ-025 FAIL: if the grant was HR or CR, set stop_attempting; pulse alert_failed for one cycle, go to IDLE.
REQ-026 Grant-to-start latency SHALL be 1 cycle.
REQ-027 Requests seen while busy (other than REQ-022) SHALL wait for IDLE.
REQ-028 At most one of alert_success and alert_failed SHALL be high in any cycle.
REQ-029 req_ack SHALL be all-zero or one-hot.

Reset
REQ-030 While reset_n is low: state IDLE; timer, retry count and latched type zero; every output 0 (including stop_attempting).
REQ-031 Reset asserted mid-transfer SHALL abort it immediately with no alert; the first grant needs one cycle in IDLE after release.

Configuration
REQ-032 With TX_RETRY_EN defined:
- A MSG failure (fail pulse or timeout) with retry count < RETRY_MAX increments the count and goes to START with no alert.
- At RETRY_MAX, FAIL is entered.
- The count clears on every new grant.
REQ-033 Without TX_RETRY_EN: no retry counter is built, and every failure goes directly to FAIL.
REQ-034 HR and CR SHALL never retry in either build.

Verification
REQ-035 msg_req=1, msg_type=3'b000; done 5 cycles after start.
- req_ack=001; phy_tx_type=000; one alert_success pulse; busy back to 0.
REQ-036 hr_req=cr_req=msg_req=1 in the same cycle.
- req_ack=100, phy_tx_type=101; after done, CR then MSG are granted in order.
REQ-037 HR grant with no PHY response.
- alert_failed exactly TIMEOUT cycles (900) after the WAIT entry cycle; stop_attempting=1.
- A later successful HR clears stop_attempting.
REQ-038 MSG in WAIT, then hr_req pulses high.
- Next cycle req_ack=100 and restart with type 101; no alert for the MSG.
REQ-039 TX_RETRY_EN, RETRY_MAX=3, PHY always fails.
- 4 start pulses, one alert_failed; without the macro, 1 start and 1 alert_failed.
REQ-040 done and fail in the same cycle -> alert_success only; reset_n low mid-WAIT -> all outputs 0 asynchronously.
